armleocpu_tlb: RTL and testbench
================================

# armleocpu_tlb

Direct-mapped SV32 translation lookaside buffer sitting directly upstream of the page table walker. It accepts 20-bit virtual page numbers from a fetch/load-store unit and returns the 4K physical page number plus 8 metadata bits. On a miss it issues a single walk to the PTW, returns the PTW result to the requester, and fills the entry when the walk succeeds. Faulting walks are never cached. A global invalidate (sfence.vma) clears all entries.

## Interface
- ENTRIES_W, default 4: log2 of entry count (16 entries); legal 1..8
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  lookup request
- req_ready  output  1  request accepted when req_valid && req_ready
- req_vpn  input  20  virtual page number (VA[31:12])
- resp_valid  output  1  one-cycle pulse, response fields valid
- resp_hit  output  1  response served from TLB (0 = came from walk)
- resp_pagefault  output  1  walk ended in page fault
- resp_accessfault  output  1  walk ended in access fault
- resp_metadata  output  8  PTE bits [7:0]
- resp_ppn  output  22  physical page number
- tlb_invalidate  input  1  clear all entries
- ptw_resolve_request  output  1  start walk (PTW resolve_request)
- ptw_virtual_address  output  20  VPN to walk
- ptw_resolve_done  input  1  walk finished pulse
- ptw_resolve_pagefault  input  1  valid with done
- ptw_resolve_accessfault  input  1  valid with done
- ptw_resolve_metadata  input  8  valid with done
- ptw_resolve_physical_address  input  22  valid with done

## Operation
- Entry: valid bit, tag = vpn[19:ENTRIES_W], metadata[7:0], ppn[21:0]; index = vpn[ENTRIES_W-1:0].
- Tag/data array read synchronously (registered), valid bits in flops.
- States: IDLE, LOOKUP, PTW_REQ, PTW_WAIT.
- IDLE: req_ready = !tlb_invalidate. On accept: latch saved_vpn = req_vpn, register array read at index, go LOOKUP.
- LOOKUP: hit = valid[idx] && tag match. Hit: resp_valid=1, resp_hit=1, metadata/ppn from entry, faults 0, go IDLE. Miss: go PTW_REQ.
- PTW_REQ: ptw_resolve_request=1 for exactly this one cycle, go PTW_WAIT. Request never held longer (PTW restarts when it returns to idle with request high).
- PTW_WAIT: on ptw_resolve_done: resp_valid=1, resp_hit=0, all resp fields copied from PTW inputs that cycle, go IDLE. Fill entry at saved index iff !pagefault && !accessfault && !drop_fill; fill sets valid, writes tag/metadata/ppn.
- ptw_virtual_address = saved_vpn at all times.
- tlb_invalidate: any state, clears all valid bits at next edge. In LOOKUP it forces miss behaviour (hit suppressed, goes PTW_REQ). In PTW_REQ/PTW_WAIT sets drop_fill; walk result still returned, not filled. drop_fill clears on return to IDLE.
- Replacement: fill overwrites whatever entry occupies the index.
- Metadata stored as returned; permission/A/D checks are downstream's job.

## Timing
- Reset (rst_n low at edge): state IDLE, all valid bits 0, drop_fill 0. All outputs 0 during/after reset except req_ready (1 in IDLE without invalidate) and ptw_virtual_address (saved_vpn, reset 0). Reset mid-walk abandons walk; PTW shares reset.
- Hit latency: accept in cycle N, resp_valid in N+1. Next request accepted N+2 (req_ready=0 outside IDLE).
- Miss latency: accept N, LOOKUP N+1, ptw_resolve_request N+2, resp_valid in the cycle of ptw_resolve_done (≥ N+3).
- Fill visible to a lookup accepted the cycle after resp_valid.
- Invalidate and req_valid same cycle in IDLE: invalidate wins, request not accepted.
- resp_valid is a single-cycle pulse; requester must always sink it.
- ptw_resolve_done outside PTW_WAIT: ignored.

## Test plan
- Reset, req_vpn=0x12345, PTW done 3 cycles after request with ppn=0x0ABCDE, meta=0xCF -> resp_valid, hit=0, ppn 0x0ABCDE; repeat same vpn -> resp 1 cycle later, hit=1, same ppn/meta, no ptw_resolve_request.
- Miss on 0x00010, PTW returns pagefault=1 -> resp_pagefault=1; repeat 0x00010 -> second walk issued (not cached). Same for accessfault.
- Fill 0x00003 then 0x10003 (same index) -> second walk, fill; 0x00003 again -> miss, walk issued.
- Fill 4 vpns, pulse tlb_invalidate in IDLE with req_valid=1 -> req_ready=0 that cycle; all 4 subsequently miss.
- Miss on 0x00007, invalidate during PTW_WAIT, PTW success -> response returned (hit=0), lookup of 0x00007 misses again.
- Assert rst_n=0 in PTW_WAIT -> state IDLE, ptw_resolve_request 0, next lookup of previously filled vpn misses.

Source files
------------

// File: rtl/armleocpu_tlb.sv
// Direct-mapped SV32 TLB in front of the page table walker.
// A miss is turned into a single PTW walk, and the entry is filled only when that walk succeeds.
module armleocpu_tlb #(
  parameter int ENTRIES_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [19:0] req_vpn,
  output logic        resp_valid,
  output logic        resp_hit,
  output logic        resp_pagefault,
  output logic        resp_accessfault,
  output logic [7:0]  resp_metadata,
  output logic [21:0] resp_ppn,
  input  logic        tlb_invalidate,
  output logic        ptw_resolve_request,
  output logic [19:0] ptw_virtual_address,
  input  logic        ptw_resolve_done,
  input  logic        ptw_resolve_pagefault,
  input  logic        ptw_resolve_accessfault,
  input  logic [7:0]  ptw_resolve_metadata,
  input  logic [21:0] ptw_resolve_physical_address
);
  localparam int ENTRIES = 1 << ENTRIES_W;
  localparam int TAG_W   = 20 - ENTRIES_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, PTW_REQ, PTW_WAIT} state_t;

  state_t               state, state_nxt;
  logic [ENTRIES-1:0]   valid;
  logic [TAG_W-1:0]     tag_mem  [ENTRIES];
  logic [7:0]           meta_mem [ENTRIES];
  logic [21:0]          ppn_mem  [ENTRIES];
  logic [TAG_W-1:0]     rd_tag;
  logic [7:0]           rd_meta;
  logic [21:0]          rd_ppn;
  logic [19:0]          saved_vpn;
  logic                 drop_fill;
  logic [ENTRIES_W-1:0] req_idx;
  logic [ENTRIES_W-1:0] saved_idx;
  logic                 accept;
  logic                 hit;
  logic                 fill;
  logic                 in_walk;

  assign req_idx   = req_vpn[ENTRIES_W-1:0];
  assign saved_idx = saved_vpn[ENTRIES_W-1:0];
  assign accept    = (state == IDLE) && req_valid && !tlb_invalidate;
  assign in_walk   = (state == PTW_REQ) || (state == PTW_WAIT);
  // An invalidate arriving in the lookup cycle must not let a stale entry answer.
  assign hit       = valid[saved_idx] && (rd_tag == saved_vpn[19:ENTRIES_W]) && !tlb_invalidate;
  assign fill      = (state == PTW_WAIT) && ptw_resolve_done && !ptw_resolve_pagefault &&
                     !ptw_resolve_accessfault && !drop_fill && !tlb_invalidate;
  assign ptw_virtual_address = saved_vpn;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid     <= '0;
      drop_fill <= 1'b0;
      saved_vpn <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        saved_vpn <= req_vpn;
      if (tlb_invalidate)
        valid <= '0;
      else if (fill)
        valid[saved_idx] <= 1'b1;
      if (state_nxt == IDLE)
        drop_fill <= 1'b0;
      else if (tlb_invalidate && in_walk)
        drop_fill <= 1'b1;
    end
  end

  // Tag/data array: registered read on accept, write on successful fill
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_tag  <= tag_mem[req_idx];
      rd_meta <= meta_mem[req_idx];
      rd_ppn  <= ppn_mem[req_idx];
    end
    if (fill) begin
      tag_mem[saved_idx]  <= saved_vpn[19:ENTRIES_W];
      meta_mem[saved_idx] <= ptw_resolve_metadata;
      ppn_mem[saved_idx]  <= ptw_resolve_physical_address;
    end
  end

  always_comb begin
    state_nxt           = state;
    req_ready           = 1'b0;
    resp_valid          = 1'b0;
    resp_hit            = 1'b0;
    resp_pagefault      = 1'b0;
    resp_accessfault    = 1'b0;
    resp_metadata       = '0;
    resp_ppn            = '0;
    ptw_resolve_request = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !tlb_invalidate;
        if (accept)
          state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          resp_valid    = 1'b1;
          resp_hit      = 1'b1;
          resp_metadata = rd_meta;
          resp_ppn      = rd_ppn;
          state_nxt     = IDLE;
        end else begin
          state_nxt = PTW_REQ;
        end
      end
      PTW_REQ: begin
        ptw_resolve_request = 1'b1;
        state_nxt           = PTW_WAIT;
      end
      PTW_WAIT: begin
        if (ptw_resolve_done) begin
          resp_valid       = 1'b1;
          resp_pagefault   = ptw_resolve_pagefault;
          resp_accessfault = ptw_resolve_accessfault;
          resp_metadata    = ptw_resolve_metadata;
          resp_ppn         = ptw_resolve_physical_address;
          state_nxt        = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_armleocpu_tlb.sv
// Bench for armleocpu_tlb: directed scenarios plus randomized traffic checked against a direct-mapped cache model.
module tb_armleocpu_tlb;
  localparam int ENTRIES_W = 4;
  localparam int ENTRIES   = 1 << ENTRIES_W;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [19:0] req_vpn;
  logic        resp_valid;
  logic        resp_hit;
  logic        resp_pagefault;
  logic        resp_accessfault;
  logic [7:0]  resp_metadata;
  logic [21:0] resp_ppn;
  logic        tlb_invalidate;
  logic        ptw_resolve_request;
  logic [19:0] ptw_virtual_address;
  logic        ptw_resolve_done;
  logic        ptw_resolve_pagefault;
  logic        ptw_resolve_accessfault;
  logic [7:0]  ptw_resolve_metadata;
  logic [21:0] ptw_resolve_physical_address;

  int checks = 0;
  int errors = 0;

  // Reference: each slot remembers the full VPN it caches, or nothing.
  bit          m_valid [ENTRIES];
  logic [19:0] m_vpn   [ENTRIES];
  logic [7:0]  m_meta  [ENTRIES];
  logic [21:0] m_ppn   [ENTRIES];

  armleocpu_tlb #(.ENTRIES_W(ENTRIES_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_vpn(req_vpn),
    .resp_valid(resp_valid),
    .resp_hit(resp_hit),
    .resp_pagefault(resp_pagefault),
    .resp_accessfault(resp_accessfault),
    .resp_metadata(resp_metadata),
    .resp_ppn(resp_ppn),
    .tlb_invalidate(tlb_invalidate),
    .ptw_resolve_request(ptw_resolve_request),
    .ptw_virtual_address(ptw_virtual_address),
    .ptw_resolve_done(ptw_resolve_done),
    .ptw_resolve_pagefault(ptw_resolve_pagefault),
    .ptw_resolve_accessfault(ptw_resolve_accessfault),
    .ptw_resolve_metadata(ptw_resolve_metadata),
    .ptw_resolve_physical_address(ptw_resolve_physical_address)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
  endtask

  // One full transaction. waits = idle PTW_WAIT cycles before done; inv pulses
  // tlb_invalidate in the first of those cycles.
  task automatic lookup(input logic [19:0] vpn, input int waits, input logic pf, input logic af,
                        input logic [7:0] meta, input logic [21:0] ppn, input bit inv);
    int idx;
    bit exp_hit;
    bit dropped;
    idx = int'(vpn) % ENTRIES;
    exp_hit = m_valid[idx] && (m_vpn[idx] == vpn);
    @(negedge clk);
    req_valid = 1'b1;
    req_vpn   = vpn;
    #1 chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_vpn = 20'($urandom);
    @(negedge clk);
    #1 chk("resp_valid_lookup", {31'd0, resp_valid}, {31'd0, exp_hit});
    chk("ptw_req_lookup", {31'd0, ptw_resolve_request}, 32'd0);
    chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
    if (exp_hit) begin
      chk("hit_flag", {31'd0, resp_hit}, 32'd1);
      chk("hit_ppn", {10'd0, resp_ppn}, {10'd0, m_ppn[idx]});
      chk("hit_meta", {24'd0, resp_metadata}, {24'd0, m_meta[idx]});
      chk("hit_faults", {30'd0, resp_pagefault, resp_accessfault}, 32'd0);
      return;
    end
    @(negedge clk);
    #1 chk("ptw_req_pulse", {31'd0, ptw_resolve_request}, 32'd1);
    chk("ptw_va", {12'd0, ptw_virtual_address}, {12'd0, vpn});
    chk("resp_valid_req", {31'd0, resp_valid}, 32'd0);
    dropped = 1'b0;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      tlb_invalidate = inv && (i == 0);
      ptw_resolve_done = 1'b0;
      #1 chk("ptw_req_held", {31'd0, ptw_resolve_request}, 32'd0);
      chk("resp_valid_wait", {31'd0, resp_valid}, 32'd0);
      if (tlb_invalidate) begin
        model_clear();
        dropped = 1'b1;
      end
    end
    @(negedge clk);
    tlb_invalidate = 1'b0;
    ptw_resolve_done = 1'b1;
    ptw_resolve_pagefault = pf;
    ptw_resolve_accessfault = af;
    ptw_resolve_metadata = meta;
    ptw_resolve_physical_address = ppn;
    #1 chk("walk_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("walk_hit", {31'd0, resp_hit}, 32'd0);
    chk("walk_faults", {30'd0, resp_pagefault, resp_accessfault}, {30'd0, pf, af});
    chk("walk_ppn", {10'd0, resp_ppn}, {10'd0, ppn});
    chk("walk_meta", {24'd0, resp_metadata}, {24'd0, meta});
    @(posedge clk);
    #1 ptw_resolve_done = 1'b0;
    ptw_resolve_physical_address = 22'($urandom);
    ptw_resolve_metadata = 8'($urandom);
    if (!pf && !af && !dropped) begin
      m_valid[idx] = 1'b1;
      m_vpn[idx]   = vpn;
      m_meta[idx]  = meta;
      m_ppn[idx]   = ppn;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_vpn = '0;
    tlb_invalidate = 1'b0;
    ptw_resolve_done = 1'b0;
    ptw_resolve_pagefault = 1'b0;
    ptw_resolve_accessfault = 1'b0;
    ptw_resolve_metadata = '0;
    ptw_resolve_physical_address = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_ptw_req", {31'd0, ptw_resolve_request}, 32'd0);
    chk("rst_ptw_va", {12'd0, ptw_virtual_address}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Miss then hit on the same page
    lookup(20'h12345, 2, 1'b0, 1'b0, 8'hCF, 22'h0ABCDE, 1'b0);
    lookup(20'h12345, 0, 1'b0, 1'b0, 8'h00, 22'h0, 1'b0);

    // Faulting walks are never cached
    lookup(20'h00010, 1, 1'b1, 1'b0, 8'h11, 22'h000111, 1'b0);
    lookup(20'h00010, 0, 1'b0, 1'b0, 8'h12, 22'h000222, 1'b0);
    lookup(20'h00020, 1, 1'b0, 1'b1, 8'h21, 22'h000333, 1'b0);
    lookup(20'h00020, 1, 1'b0, 1'b0, 8'h22, 22'h000444, 1'b0);

    // Conflict on a shared index
    lookup(20'h00003, 0, 1'b0, 1'b0, 8'h33, 22'h003003, 1'b0);
    lookup(20'h10003, 1, 1'b0, 1'b0, 8'h44, 22'h103103, 1'b0);
    lookup(20'h00003, 2, 1'b0, 1'b0, 8'h55, 22'h003555, 1'b0);
    lookup(20'h10003, 0, 1'b0, 1'b0, 8'h66, 22'h103666, 1'b0);

    // Invalidate beats a simultaneous request in IDLE
    lookup(20'h00001, 0, 1'b0, 1'b0, 8'h01, 22'h000001, 1'b0);
    lookup(20'h00002, 0, 1'b0, 1'b0, 8'h02, 22'h000002, 1'b0);
    lookup(20'h00004, 0, 1'b0, 1'b0, 8'h04, 22'h000004, 1'b0);
    lookup(20'h00005, 0, 1'b0, 1'b0, 8'h05, 22'h000005, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_vpn = 20'h00001;
    tlb_invalidate = 1'b1;
    #1 chk("inv_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    tlb_invalidate = 1'b0;
    model_clear();
    @(negedge clk);
    #1 chk("inv_not_accepted", {31'd0, req_ready}, 32'd1);
    chk("inv_no_resp", {31'd0, resp_valid}, 32'd0);
    lookup(20'h00001, 0, 1'b0, 1'b0, 8'hA1, 22'h0000A1, 1'b0);
    lookup(20'h00002, 0, 1'b0, 1'b0, 8'hA2, 22'h0000A2, 1'b0);
    lookup(20'h00004, 0, 1'b0, 1'b0, 8'hA4, 22'h0000A4, 1'b0);
    lookup(20'h00005, 0, 1'b0, 1'b0, 8'hA5, 22'h0000A5, 1'b0);

    // Invalidate during the walk: result returned but not filled
    lookup(20'h00007, 2, 1'b0, 1'b0, 8'h77, 22'h007777, 1'b1);
    lookup(20'h00007, 0, 1'b0, 1'b0, 8'h78, 22'h007778, 1'b0);

    // Stray done in IDLE is ignored
    @(negedge clk);
    ptw_resolve_done = 1'b1;
    #1 chk("stray_done", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1 ptw_resolve_done = 1'b0;

    // Reset in the middle of a walk
    lookup(20'h00009, 0, 1'b0, 1'b0, 8'h99, 22'h009999, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_vpn = 20'h0000B;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 chk("rst_walk_req", {31'd0, ptw_resolve_request}, 32'd0);
    chk("rst_walk_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_walk_resp", {31'd0, resp_valid}, 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    lookup(20'h00009, 1, 1'b0, 1'b0, 8'h9A, 22'h00999A, 1'b0);

    // Randomized traffic over a small VPN pool to provoke hits and conflicts
    for (int n = 0; n < 60; n++) begin
      logic [19:0] v;
      int w;
      bit pf, af, inv;
      v   = {3'($urandom_range(0, 3)), 13'd0, 4'($urandom_range(0, 5))};
      w   = $urandom_range(0, 3);
      pf  = ($urandom_range(0, 7) == 0);
      af  = !pf && ($urandom_range(0, 7) == 0);
      inv = (w > 0) && ($urandom_range(0, 5) == 0);
      lookup(v, w, pf, af, 8'($urandom), 22'($urandom), inv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
